rv_decode_stage: RTL and testbench

Registered RV32I decode stage between instruction fetch and execute. Accepts one instruction word plus PC per handshake, and splits it into register addresses, function fields, a format class and a sign-extended immediate. Extends the base opcode set with JAL, JALR, LUI and AUIPC, and flags illegal encodings. Width is parametrised so the same stage serves the RV32 core now and wider datapaths later.

---
 rtl/rv_decode_stage.sv | 160 ++++++++++++++++
 tb/tb_rv_decode_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: one registered slot between fetch and execute.
// Splits an instruction into register indices, function fields, a format class and an immediate.
module rv_decode_stage #(
    parameter int XLEN         = 32,
    parameter int ADDR         = 5,
    parameter int ILLEGAL_KILL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [2:0]        out_fmt,
    output logic              out_is_auipc,
    output logic [ADDR-1:0]   out_rd,
    output logic [ADDR-1:0]   out_rs1,
    output logic [ADDR-1:0]   out_rs2,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_rd_we,
    output logic              out_illegal
);
    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_LD = 3'd2, FMT_S = 3'd3,
                           FMT_B = 3'd4, FMT_J = 3'd5, FMT_JR = 3'd6, FMT_U = 3'd7;
    localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LD = 5'b00000, OP_ST = 5'b01000,
                           OP_BR = 5'b11000, OP_JAL = 5'b11011, OP_JALR = 5'b11001,
                           OP_LUI = 5'b01101, OP_AUIPC = 5'b00101;
    localparam logic KILL = (ILLEGAL_KILL != 0);

    logic [2:0]  f3;
    logic [6:0]  f7;
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];

    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [ADDR-1:0] dec_rd, dec_rs1, dec_rs2;
    logic [6:0]      dec_f7;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_rd_we, dec_auipc;

    // Format is taken from opcode[6:2] so that a bad instr[1:0] still decodes best-effort.
    always_comb begin
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
        case (in_instr[6:2])
            OP_R: begin
                dec_fmt = FMT_R;
                if (f7 != 7'b0000000 && f7 != 7'b0100000) dec_illegal = 1'b1;
                if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101) dec_illegal = 1'b1;
            end
            OP_I: begin
                dec_fmt = FMT_I;
                if (f3 == 3'b001 && f7 != 7'b0000000) dec_illegal = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) dec_illegal = 1'b1;
            end
            OP_LD: begin
                dec_fmt = FMT_LD;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec_illegal = 1'b1;
            end
            OP_ST: begin
                dec_fmt = FMT_S;
                if (f3 >= 3'b011) dec_illegal = 1'b1;
            end
            OP_BR: begin
                dec_fmt = FMT_B;
                if (f3 == 3'b010 || f3 == 3'b011) dec_illegal = 1'b1;
            end
            OP_JAL:  dec_fmt = FMT_J;
            OP_JALR: begin
                dec_fmt = FMT_JR;
                if (f3 != 3'b000) dec_illegal = 1'b1;
            end
            OP_LUI, OP_AUIPC: dec_fmt = FMT_U;
            default: dec_illegal = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) dec_illegal = 1'b1;
    end

    always_comb begin
        dec_rd  = (dec_fmt == FMT_S || dec_fmt == FMT_B) ? '0 : ADDR'(in_instr[11:7]);
        dec_rs1 = (dec_fmt == FMT_J || dec_fmt == FMT_U) ? '0 : ADDR'(in_instr[19:15]);
        dec_rs2 = (dec_fmt == FMT_R || dec_fmt == FMT_S || dec_fmt == FMT_B)
                  ? ADDR'(in_instr[24:20]) : '0;
        dec_f7  = (dec_fmt == FMT_R || (dec_fmt == FMT_I && (f3 == 3'b001 || f3 == 3'b101)))
                  ? f7 : 7'd0;
        case (dec_fmt)
            FMT_I, FMT_LD, FMT_JR: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:  imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            FMT_J:  imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            FMT_U:  imm32 = {in_instr[31:12], 12'd0};
            default: imm32 = 32'd0;
        endcase
        dec_imm   = XLEN'($signed(imm32));
        dec_auipc = (dec_fmt == FMT_U) && !in_instr[5];
        dec_rd_we = (dec_rd != '0) && dec_fmt != FMT_S && dec_fmt != FMT_B && !dec_illegal;
    end

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
    logic [2:0]      fmt_q, fmt_d, f3_q, f3_d;
    logic            auipc_q, auipc_d, rd_we_q, rd_we_d, illegal_q, illegal_d;
    logic [ADDR-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [6:0]      f7_q, f7_d;
    logic            accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;   pc_d = pc_q;       imm_d = imm_q;     fmt_d = fmt_q;
        f3_d = f3_q;         auipc_d = auipc_q; rd_we_d = rd_we_q; illegal_d = illegal_q;
        rd_d = rd_q;         rs1_d = rs1_q;     rs2_d = rs2_q;     f7_d = f7_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept && !(KILL && dec_illegal)) begin
            valid_d = 1'b1;      pc_d = in_pc;         imm_d = dec_imm;     fmt_d = dec_fmt;
            f3_d = f3;           auipc_d = dec_auipc;  rd_we_d = dec_rd_we; illegal_d = dec_illegal;
            rd_d = dec_rd;       rs1_d = dec_rs1;      rs2_d = dec_rs2;     f7_d = dec_f7;
        end else if (out_ready) begin
            // Also covers a killed illegal accept: the slot is either empty or draining.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;  pc_q <= '0;     imm_q <= '0;     fmt_q <= '0;
            f3_q <= '0;       auipc_q <= 1'b0; rd_we_q <= 1'b0; illegal_q <= 1'b0;
            rd_q <= '0;       rs1_q <= '0;     rs2_q <= '0;     f7_q <= '0;
        end else begin
            valid_q <= valid_d;  pc_q <= pc_d;       imm_q <= imm_d;     fmt_q <= fmt_d;
            f3_q <= f3_d;        auipc_q <= auipc_d; rd_we_q <= rd_we_d; illegal_q <= illegal_d;
            rd_q <= rd_d;        rs1_q <= rs1_d;     rs2_q <= rs2_d;     f7_q <= f7_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_fmt      = fmt_q;
    assign out_is_auipc = auipc_q;
    assign out_rd       = rd_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_funct3   = f3_q;
    assign out_funct7   = f7_q;
    assign out_imm      = imm_q;
    assign out_rd_we    = rd_we_q;
    assign out_illegal  = illegal_q;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: driver pushes expected bundles, a negedge monitor pops and compares.
module tb_rv_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid_k = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_ready_k = 1'b1;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;

    logic        in_ready, out_valid, out_is_auipc, out_rd_we, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [2:0]  out_fmt, out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [6:0]  out_funct7;

    logic        k_in_ready, k_out_valid, k_is_auipc, k_rd_we, k_illegal;
    logic [31:0] k_pc, k_imm;
    logic [2:0]  k_fmt, k_funct3;
    logic [4:0]  k_rd, k_rs1, k_rs2;
    logic [6:0]  k_funct7;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .ADDR(5), .ILLEGAL_KILL(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_fmt(out_fmt), .out_is_auipc(out_is_auipc), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_rd_we(out_rd_we), .out_illegal(out_illegal));

    rv_decode_stage #(.XLEN(32), .ADDR(5), .ILLEGAL_KILL(1)) u_kill (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid_k), .in_ready(k_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(k_out_valid), .out_ready(out_ready_k),
        .out_pc(k_pc), .out_fmt(k_fmt), .out_is_auipc(k_is_auipc), .out_rd(k_rd),
        .out_rs1(k_rs1), .out_rs2(k_rs2), .out_funct3(k_funct3), .out_funct7(k_funct7),
        .out_imm(k_imm), .out_rd_we(k_rd_we), .out_illegal(k_illegal));

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic        auipc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t mk(logic [31:0] pc, logic [2:0] fmt, logic auipc, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                                logic [31:0] imm, logic we, logic ill);
        exp_t e;
        e.pc = pc; e.fmt = fmt; e.auipc = auipc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.f3 = f3; e.f7 = f7; e.imm = imm; e.we = we; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t act();
        return mk(out_pc, out_fmt, out_is_auipc, out_rd, out_rs1, out_rs2, out_funct3,
                  out_funct7, out_imm, out_rd_we, out_illegal);
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every cycle the stage holds a bundle it must equal the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 128'(in_ready), 128'(!out_valid || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 128'(out_valid), 128'(0));
                end else begin
                    check($sformatf("bundle_pc%h", q[0].pc), 128'(act()), 128'(q[0]));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] ins, input exp_t e, input bit keep);
        bit acc, ok;
        ok = 0;
        in_valid = 1'b1; in_instr = ins; in_pc = e.pc;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin ok = 1; break; end
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 128'(0), 128'(1));
        else if (keep) q.push_back(e);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check("drain_left", 128'(q.size()), 128'(0));
    endtask

    task automatic kill_chk(input logic [31:0] ins, input logic want_v, input logic [4:0] want_rd);
        in_instr = ins; in_pc = 32'h300; in_valid_k = 1'b1;
        @(posedge clk); #1;
        in_valid_k = 1'b0;
        @(negedge clk);
        check($sformatf("kill_valid_%h", ins), 128'(k_out_valid), 128'(want_v));
        if (want_v) check($sformatf("kill_rd_%h", ins), 128'(k_rd), 128'(want_rd));
        @(posedge clk); #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_valid", 128'(out_valid), 128'(0));
        check("reset_data", 128'(act()), 128'(0));
        check("reset_kill_valid", 128'(k_out_valid), 128'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'h002081B3, mk(32'h100, 0, 0, 3, 1, 2, 0, 7'h00, 32'h0, 1, 0), 1);
        send(32'hFFF00293, mk(32'h104, 1, 0, 5, 0, 0, 0, 7'h00, 32'hFFFFFFFF, 1, 0), 1);
        send(32'hFE208EE3, mk(32'h108, 4, 0, 0, 1, 2, 0, 7'h00, 32'hFFFFFFFC, 0, 0), 1);
        send(32'h008000EF, mk(32'h10C, 5, 0, 1, 0, 0, 0, 7'h00, 32'h8, 1, 0), 1);
        send(32'h123453B7, mk(32'h110, 7, 0, 7, 0, 0, 5, 7'h00, 32'h12345000, 1, 0), 1);
        send(32'h00001117, mk(32'h114, 7, 1, 2, 0, 0, 1, 7'h00, 32'h1000, 1, 0), 1);
        send(32'h00512623, mk(32'h118, 3, 0, 0, 2, 5, 2, 7'h00, 32'hC, 0, 0), 1);
        send(32'hFF80A303, mk(32'h11C, 2, 0, 6, 1, 0, 2, 7'h00, 32'hFFFFFFF8, 1, 0), 1);
        send(32'h00008067, mk(32'h120, 6, 0, 0, 1, 0, 0, 7'h00, 32'h0, 0, 0), 1);
        send(32'h40325213, mk(32'h124, 1, 0, 4, 4, 0, 5, 7'h20, 32'h403, 1, 0), 1);
        send(32'h40A48433, mk(32'h128, 0, 0, 8, 9, 10, 0, 7'h20, 32'h0, 1, 0), 1);
        send(32'h40001033, mk(32'h12C, 0, 0, 0, 0, 0, 1, 7'h20, 32'h0, 0, 1), 1);
        send(32'h00000010, mk(32'h130, 1, 0, 0, 0, 0, 0, 7'h00, 32'h0, 0, 1), 1);
        send(32'h00003083, mk(32'h134, 2, 0, 1, 0, 0, 3, 7'h00, 32'h0, 0, 1), 1);
        drain();

        // Four-deep stream with a three-cycle downstream stall after the second item.
        send(32'h002081B3, mk(32'h200, 0, 0, 3, 1, 2, 0, 7'h00, 32'h0, 1, 0), 1);
        send(32'h40A48433, mk(32'h204, 0, 0, 8, 9, 10, 0, 7'h20, 32'h0, 1, 0), 1);
        fork
            begin
                send(32'hFF80A303, mk(32'h208, 2, 0, 6, 1, 0, 2, 7'h00, 32'hFFFFFFF8, 1, 0), 1);
                send(32'h00512623, mk(32'h20C, 3, 0, 0, 2, 5, 2, 7'h00, 32'hC, 0, 0), 1);
            end
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        in_valid = 1'b1; flush = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h240;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(32'hFFF00293, mk(32'h280, 1, 0, 5, 0, 0, 0, 7'h00, 32'hFFFFFFFF, 1, 0), 1);
        @(negedge clk);
        check("stall_hold_valid", 128'(out_valid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'(0));
        check("async_rst_data", 128'(act()), 128'(0));
        check("async_rst_in_ready", 128'(in_ready), 128'(1));
        q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;

        kill_chk(32'h002081B3, 1'b1, 5'd3);
        kill_chk(32'h40001033, 1'b0, 5'd0);
        kill_chk(32'h00000010, 1'b0, 5'd0);
        kill_chk(32'hFFF00293, 1'b1, 5'd5);

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
